mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multi-cycle control sequencer for the MIPS core.
- Replaces the single-cycle combinational control decode with a state machine that time-shares one ALU and one unified memory across fetch, decode, execute, memory and writeback steps.
- Drives datapath mux selects and write strobes each cycle.
- Stalls on a memory ready handshake and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready before trapping (1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- opcode  input  6  instruction register bits [31:26]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by zero (beq)
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register file write data select: 1 = MDR
- reg_dst  output  1  register file write address select: 1 = rd [15:11], 0 = rt [20:16]
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B select: 00 = register B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct
- pc_source  output  2  PC input select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  4  current state encoding (debug)
- halted  output  1  trap flag

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=15.
- Reset (rst=0, async): state=FETCH, wait counter=0, halted=0. Outputs are combinational from state, so they take FETCH values immediately.
- Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1; then next state is DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - anything else -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next is FETCH. The datapath ANDs pc_write_cond with zero.
- JUMP: pc_write=1, pc_source=10. Next is FETCH.
- Memory timeout:
  - In FETCH, MEM_RD and MEM_WR, an 8-bit wait counter increments each cycle mem_ready=0.
  - The counter clears on entry to any memory state and whenever mem_ready=1.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0, next state is TRAP. No strobe fires that cycle.
- mem_ready is ignored outside the memory states.
- TRAP: all strobes 0, halted=1. Absorbing; exit only by reset.
- Latencies with zero memory wait:
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Reset asserted mid-instruction aborts immediately. No partial write strobe survives reset assertion.

Optional Feature:
- Macro: MIPS_MC_ADDI_EN
- Defined: opcode 001000 (addi) in DECODE goes to ADDI_EXEC, then ADDI_WB, then FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - addi latency: 4 cycles.
- Undefined: states 10 and 11 do not exist; opcode 001000 goes to TRAP like any illegal opcode.

Test Plan:
- Reset held 3 cycles then released, mem_ready=1, opcode=000000 -> state sequence 0,1,6,7,0. pc_write=1 and ir_write=1 in cycle 1 only; reg_write=1 with reg_dst=1 in R_WB.
- lw (100011), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, i_or_d=1 throughout, then MEM_WB with reg_write=1 and mem_to_reg=1.
- sw (101011), mem_ready=1 -> sequence 0,1,2,5,0. mem_write=1 for exactly one cycle; reg_write never asserts.
- beq (000100) and j (000010) -> BRANCH shows pc_write_cond=1, alu_op=01, pc_source=01. JUMP shows pc_write=1, pc_source=10. Each instruction takes 3 cycles.
- mem_ready tied 0 in FETCH with MEM_TIMEOUT=15 -> TRAP after 15 cycles, halted=1. halted stays 1 until rst=0, then state=0 asynchronously.
- opcode 001000: with MIPS_MC_ADDI_EN -> sequence 0,1,10,11,0 with reg_write, reg_dst=0. Without it -> TRAP after DECODE.

Source files
------------

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multi-cycle MIPS control sequencer with memory stall/timeout trap
// Optional addi support is enabled by defining MIPS_MC_ADDI_EN.
module mips_mc_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
`ifdef MIPS_MC_ADDI_EN
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
`endif
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       halted_q, halted_d;

    logic [7:0] wait_cnt_inc;
    logic       mem_state;
    logic       timeout;

    // The datapath qualifies pc_write_cond with zero itself.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
        end
    end

    assign wait_cnt_inc = wait_cnt_q + 8'd1;
    assign mem_state    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout      = !mem_ready && (wait_cnt_inc == TIMEOUT_CNT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_TRAP;
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_TRAP;
            end
            S_EXEC:      state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
`ifdef MIPS_MC_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
`endif
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    // Counter restarts on every state change so each memory access gets a fresh budget.
    always_comb begin
        wait_cnt_d = 8'd0;
        if (state_d == state_q && mem_state && !mem_ready) begin
            wait_cnt_d = wait_cnt_inc;
        end
        halted_d = (state_d == S_TRAP);
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MIPS_MC_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state  = state_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - directed self-checking bench for mips_mc_control
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    mips_mc_control #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_halted", 32'(halted), 32'd0);
        tick();
        rst = 1'b1;
    endtask

    int mw_cnt, rw_cnt, stay;

    initial begin
        rst = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd1);
        check("rst_alu_src_b", 32'(alu_src_b), 32'd1);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        rst = 1'b1; mem_ready = 1'b1;

        // R-type: 0,1,6,7,0
        #1;
        check("r_fetch_pcw", 32'(pc_write), 32'd1);
        check("r_fetch_irw", 32'(ir_write), 32'd1);
        tick();
        check("r_dec_state", 32'(state), 32'd1);
        check("r_dec_pcw", 32'(pc_write), 32'd0);
        check("r_dec_irw", 32'(ir_write), 32'd0);
        check("r_dec_srcb", 32'(alu_src_b), 32'd3);
        tick();
        check("r_exec_state", 32'(state), 32'd6);
        check("r_exec_aluop", 32'(alu_op), 32'd2);
        check("r_exec_srca", 32'(alu_src_a), 32'd1);
        tick();
        check("r_wb_state", 32'(state), 32'd7);
        check("r_wb_regw", 32'(reg_write), 32'd1);
        check("r_wb_regdst", 32'(reg_dst), 32'd1);
        tick();
        check("r_back_fetch", 32'(state), 32'd0);

        // lw with three stall cycles in MEM_RD
        opcode = 6'b100011;
        tick();
        check("lw_dec_state", 32'(state), 32'd1);
        tick();
        check("lw_addr_state", 32'(state), 32'd2);
        check("lw_addr_srcb", 32'(alu_src_b), 32'd2);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lw_rd_state%0d", i), 32'(state), 32'd3);
            check($sformatf("lw_rd_iord%0d", i), 32'(i_or_d), 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        check("lw_rd_state3", 32'(state), 32'd3);
        check("lw_rd_memrd3", 32'(mem_read), 32'd1);
        tick();
        check("lw_wb_state", 32'(state), 32'd4);
        check("lw_wb_regw", 32'(reg_write), 32'd1);
        check("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
        check("lw_wb_regdst", 32'(reg_dst), 32'd0);
        tick();
        check("lw_back_fetch", 32'(state), 32'd0);

        // sw: 0,1,2,5,0
        opcode = 6'b101011;
        mw_cnt = 0; rw_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            mw_cnt += int'(mem_write);
            rw_cnt += int'(reg_write);
            tick();
            if (i == 2) check("sw_wr_state", 32'(state), 32'd5);
        end
        check("sw_back_fetch", 32'(state), 32'd0);
        check("sw_memw_cycles", 32'(mw_cnt), 32'd1);
        check("sw_regw_cycles", 32'(rw_cnt), 32'd0);

        // beq: 0,1,8,0
        opcode = 6'b000100; zero = 1'b1;
        tick();
        tick();
        check("beq_state", 32'(state), 32'd8);
        check("beq_pcwc", 32'(pc_write_cond), 32'd1);
        check("beq_aluop", 32'(alu_op), 32'd1);
        check("beq_pcsrc", 32'(pc_source), 32'd1);
        check("beq_pcw", 32'(pc_write), 32'd0);
        tick();
        check("beq_back_fetch", 32'(state), 32'd0);

        // j: 0,1,9,0
        opcode = 6'b000010; zero = 1'b0;
        tick();
        tick();
        check("j_state", 32'(state), 32'd9);
        check("j_pcw", 32'(pc_write), 32'd1);
        check("j_pcsrc", 32'(pc_source), 32'd2);
        tick();
        check("j_back_fetch", 32'(state), 32'd0);

        // addi
        opcode = 6'b001000;
        tick();
        check("addi_dec_state", 32'(state), 32'd1);
        tick();
`ifdef MIPS_MC_ADDI_EN
        check("addi_exec_state", 32'(state), 32'd10);
        check("addi_exec_srcb", 32'(alu_src_b), 32'd2);
        tick();
        check("addi_wb_state", 32'(state), 32'd11);
        check("addi_wb_regw", 32'(reg_write), 32'd1);
        check("addi_wb_regdst", 32'(reg_dst), 32'd0);
        tick();
        check("addi_back_fetch", 32'(state), 32'd0);
`else
        check("addi_trap_state", 32'(state), 32'd15);
        check("addi_trap_halted", 32'(halted), 32'd1);
        check("addi_trap_memrd", 32'(mem_read), 32'd0);
`endif
        pulse_reset();

        // fetch timeout: 15 cycles in FETCH, then TRAP
        opcode = 6'b000000; mem_ready = 1'b0;
        stay = 0;
        for (int i = 0; i < 15; i++) begin
            if (state == 4'd0) stay++;
            tick();
        end
        check("to_fetch_cycles", 32'(stay), 32'd15);
        check("to_trap_state", 32'(state), 32'd15);
        check("to_trap_halted", 32'(halted), 32'd1);
        check("to_trap_memrd", 32'(mem_read), 32'd0);
        mem_ready = 1'b1;
        repeat (3) tick();
        check("to_trap_sticky", 32'(state), 32'd15);
        check("to_halt_sticky", 32'(halted), 32'd1);
        check("to_trap_pcw", 32'(pc_write), 32'd0);
        #2;
        pulse_reset();
        check("post_rst_pcw", 32'(pc_write), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
